// File: rtl/aes_byte_stream_if_if.sv
// Bundle of the byte-stream handshakes and the AES core word/reset/ciphertext nets.
// The slave modport is the stream block; the master modport is its environment.
interface aes_byte_stream_if_if;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_byte;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_byte;
  logic [127:0] core_data;
  logic [127:0] core_key;
  logic         core_rst_n;
  logic [127:0] core_ct;
  logic         busy;

  modport slave (
    input  in_valid, in_byte, out_ready, core_ct,
    output in_ready, out_valid, out_byte, core_data, core_key, core_rst_n, busy
  );

  modport master (
    output in_valid, in_byte, out_ready, core_ct,
    input  in_ready, out_valid, out_byte, core_data, core_key, core_rst_n, busy
  );
endinterface

// File: rtl/aes_byte_stream_if.sv
// Byte-serial loader/unloader around an AES-128 core with no start/done handshake:
// shifts in key then plaintext, releases core reset for CORE_LAT edges, streams out ciphertext.
module aes_byte_stream_if #(
  parameter int unsigned CORE_LAT = 12
) (
  input  logic                 i_clk,
  input  logic                 i_reset,   // asynchronous, active low
  aes_byte_stream_if_if.slave  io_bus
);

  typedef enum logic [1:0] {StLoadKey, StLoadPt, StRun, StOut} state_e;

  localparam logic [7:0] LastCyc = 8'(CORE_LAT - 1);

  state_e       r_state;
  logic [3:0]   r_byte_cnt;
  logic [7:0]   r_cyc_cnt;
  logic [127:0] r_key;
  logic [127:0] r_data;
  logic [127:0] r_ct;
  logic         r_in_ready;
  logic         r_out_valid;
  logic         r_core_rst_n;
  logic         r_busy;
  logic         w_in_xfer;
  logic         w_out_xfer;

  assign w_in_xfer  = io_bus.in_valid & r_in_ready;
  assign w_out_xfer = io_bus.out_ready & r_out_valid;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= StLoadKey;
      r_byte_cnt   <= '0;
      r_cyc_cnt    <= '0;
      r_key        <= '0;
      r_data       <= '0;
      r_ct         <= '0;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_core_rst_n <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      unique case (r_state)
        StLoadKey: begin
          r_in_ready <= 1'b1;
          if (w_in_xfer) begin
            r_key      <= {r_key[119:0], io_bus.in_byte};
            r_byte_cnt <= r_byte_cnt + 4'd1;
            if (r_byte_cnt == 4'd15) begin
              r_state    <= StLoadPt;
              r_byte_cnt <= '0;
            end
          end
        end
        StLoadPt: begin
          r_in_ready <= 1'b1;
          if (w_in_xfer) begin
            r_data     <= {r_data[119:0], io_bus.in_byte};
            r_byte_cnt <= r_byte_cnt + 4'd1;
            if (r_byte_cnt == 4'd15) begin
              r_state      <= StRun;
              r_byte_cnt   <= '0;
              r_cyc_cnt    <= '0;
              r_in_ready   <= 1'b0;
              r_core_rst_n <= 1'b1;
              r_busy       <= 1'b1;
            end
          end
        end
        StRun: begin
          r_cyc_cnt <= r_cyc_cnt + 8'd1;
          // Capture on the edge where the count reaches CORE_LAT; clear the core while unloading.
          if (r_cyc_cnt == LastCyc) begin
            r_ct         <= io_bus.core_ct;
            r_state      <= StOut;
            r_out_valid  <= 1'b1;
            r_core_rst_n <= 1'b0;
          end
        end
        StOut: begin
          if (w_out_xfer) begin
            r_ct       <= {r_ct[119:0], 8'h00};
            r_byte_cnt <= r_byte_cnt + 4'd1;
            if (r_byte_cnt == 4'd15) begin
              r_state     <= StLoadKey;
              r_byte_cnt  <= '0;
              r_out_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_in_ready  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign io_bus.in_ready   = r_in_ready;
  assign io_bus.out_valid  = r_out_valid;
  assign io_bus.out_byte   = r_ct[127:120];
  assign io_bus.core_key   = r_key;
  assign io_bus.core_data  = r_data;
  assign io_bus.core_rst_n = r_core_rst_n;
  assign io_bus.busy       = r_busy;

endmodule

// File: tb/tb_aes_byte_stream_if.sv
// Directed + randomized bench for aes_byte_stream_if with a behavioural AES-core stub
// (known FIPS-197 vectors, otherwise a fixed mixing function) and block-level expectations.
module tb_aes_byte_stream_if;
  localparam int unsigned CORE_LAT = 12;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   core_cnt = 0;
  int   hi_cnt = 0;
  logic prev_hi = 1'b0;
  logic [127:0] prev_key = '0;
  logic [127:0] prev_data = '0;

  aes_byte_stream_if_if bus();

  aes_byte_stream_if #(.CORE_LAT(CORE_LAT)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .io_bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] d);
    if (k == KEY_B && d == PT_B) return CT_B;
    if (k == KEY_C && d == PT_C) return CT_C;
    return {d[63:0], d[127:64]} ^ k ^ {k[7:0], k[127:8]};
  endfunction

  function automatic logic [127:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Core stub: junk while held in reset, result valid after the 11th falling edge out of reset.
  always @(negedge clk) begin
    if (!bus.core_rst_n) begin
      core_cnt    <= 0;
      bus.core_ct <= rnd_word();
    end else if (core_cnt < 11) begin
      core_cnt <= core_cnt + 1;
      if (core_cnt == 10) bus.core_ct <= core_fn(bus.core_key, bus.core_data);
    end
  end

  // Continuous protocol checks.
  always @(negedge clk) begin
    if (bus.core_rst_n && prev_hi) begin
      chk("key_stable_run", bus.core_key, prev_key);
      chk("data_stable_run", bus.core_data, prev_data);
    end
    if (bus.core_rst_n) hi_cnt <= hi_cnt + 1;
    else if (prev_hi) begin
      chk("core_rst_n_high_len", 128'(hi_cnt), 128'(CORE_LAT));
      hi_cnt <= 0;
    end
    if (bus.busy) chk("in_ready_low_busy", 128'(bus.in_ready), 128'd0);
    prev_hi   <= bus.core_rst_n;
    prev_key  <= bus.core_key;
    prev_data <= bus.core_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int n;
    if (rnd) begin
      repeat ($urandom_range(0, 2)) begin
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'($urandom);
        step();
      end
    end
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk("in_ready_timeout", 128'(n < 200), 128'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [127:0] w, input bit rnd);
    for (int i = 0; i < 16; i++) send_byte(w[127-8*i -: 8], rnd);
  endtask

  task automatic wait_valid(input bit rnd, output int n);
    n = 0;
    while (!bus.out_valid && n < 400) begin
      if (rnd) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_byte  = 8'($urandom);
      end
      step();
      n++;
    end
    bus.in_valid = 1'b0;
    chk("out_valid_timeout", 128'(bus.out_valid), 128'd1);
  endtask

  task automatic recv_bytes(input int nb, input bit rnd, output logic [127:0] ct);
    bit got;
    int n;
    ct = '0;
    for (int i = 0; i < nb; i++) begin
      got = 1'b0;
      n = 0;
      while (!got && n < 300) begin
        bus.out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (rnd) begin
          bus.in_valid = 1'($urandom_range(0, 1));
          bus.in_byte  = 8'($urandom);
        end
        if (bus.out_valid && bus.out_ready) begin
          ct  = {ct[119:0], bus.out_byte};
          got = 1'b1;
        end
        step();
        n++;
      end
      if (!got) chk("out_byte_timeout", 128'(got), 128'd1);
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 128'(bus.in_ready), 128'd0);
    chk({tag, "_out_valid"}, 128'(bus.out_valid), 128'd0);
    chk({tag, "_out_byte"}, 128'(bus.out_byte), 128'd0);
    chk({tag, "_core_data"}, bus.core_data, 128'd0);
    chk({tag, "_core_key"}, bus.core_key, 128'd0);
    chk({tag, "_core_rst_n"}, 128'(bus.core_rst_n), 128'd0);
    chk({tag, "_busy"}, 128'(bus.busy), 128'd0);
  endtask

  // Full block with random stalls, checked against the block-level model.
  task automatic rand_block(input string tag);
    logic [127:0] k, p, ct;
    int n;
    k = rnd_word();
    p = rnd_word();
    send_word(k, 1'b1);
    send_word(p, 1'b1);
    chk({tag, "_core_key"}, bus.core_key, k);
    chk({tag, "_core_data"}, bus.core_data, p);
    wait_valid(1'b1, n);
    recv_bytes(16, 1'b1, ct);
    chk({tag, "_ct"}, ct, core_fn(k, p));
    chk({tag, "_out_valid_end"}, 128'(bus.out_valid), 128'd0);
  endtask

  initial begin
    logic [127:0] ct;
    int n;
    int c0;
    bus.in_valid  = 1'b0;
    bus.in_byte   = 8'h00;
    bus.out_ready = 1'b0;

    // Reset state, then first edge after release raises in_ready.
    step();
    step();
    chk_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready_before_edge", 128'(bus.in_ready), 128'd0);
    step();
    chk("release_in_ready_after_edge", 128'(bus.in_ready), 128'd1);

    // FIPS-197 App. B, no stalls: exact latency and a 16-cycle unload.
    send_word(KEY_B, 1'b0);
    send_word(PT_B, 1'b0);
    chk("b_core_rst_n_high", 128'(bus.core_rst_n), 128'd1);
    chk("b_busy", 128'(bus.busy), 128'd1);
    chk("b_in_ready_run", 128'(bus.in_ready), 128'd0);
    chk("b_core_key", bus.core_key, KEY_B);
    wait_valid(1'b0, n);
    chk("b_latency_edges", 128'(n + 1), 128'(CORE_LAT + 1));
    chk("b_core_rst_n_out", 128'(bus.core_rst_n), 128'd0);
    c0 = cyc;
    recv_bytes(16, 1'b0, ct);
    chk("b_unload_cycles", 128'(cyc - c0), 128'd16);
    chk("b_ct", ct, CT_B);
    chk("b_out_valid_end", 128'(bus.out_valid), 128'd0);
    chk("b_busy_end", 128'(bus.busy), 128'd0);
    chk("b_in_ready_end", 128'(bus.in_ready), 128'd1);

    // FIPS-197 App. C.1 back-to-back, random gaps on both sides.
    send_word(KEY_C, 1'b1);
    send_word(PT_C, 1'b1);
    wait_valid(1'b1, n);
    recv_bytes(16, 1'b1, ct);
    chk("c_ct", ct, CT_C);
    chk("c_out_valid_end", 128'(bus.out_valid), 128'd0);

    // Reset after 20 input bytes, then a fresh block.
    send_word(rnd_word(), 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("rst_load");
    step();
    step();
    chk_reset_vals("rst_load_hold");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    rand_block("after_load_rst");

    // Reset in OUT after 5 bytes: partial stream correct, outputs drop immediately.
    begin
      logic [127:0] k, p, e;
      k = rnd_word();
      p = rnd_word();
      e = core_fn(k, p);
      send_word(k, 1'b1);
      send_word(p, 1'b1);
      wait_valid(1'b1, n);
      recv_bytes(5, 1'b1, ct);
      chk("out_rst_partial", ct[39:0], e[127:88]);
      chk("out_rst_valid_before", 128'(bus.out_valid), 128'd1);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("rst_out");
      step();
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("rst_out_no_stray_valid", 128'(bus.out_valid), 128'd0);
    end
    rand_block("after_out_rst");

    for (int i = 0; i < 3; i++) rand_block("rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
